strobe_sched: RTL and testbench

STROBE_SCHED -- requirements
Module: strobe_sched

---
 rtl/strobe_sched.sv | 101 ++++++++++
 tb/tb_strobe_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_sched.sv
// Round-robin strobe scheduler: per-channel periodic timers raise pending requests,
// and each base tick grants at most one of them as a registered single-cycle strobe.
module strobe_sched #(
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_tick,
    input  logic                        i_cfg_valid,
    input  logic [$clog2(NUM_CH)-1:0]   i_cfg_ch,
    input  logic [PERIOD_W-1:0]         i_cfg_period,
    input  logic [NUM_CH-1:0]           i_clear_overrun,
    output logic [NUM_CH-1:0]           o_strobe,
    output logic [NUM_CH-1:0]           o_overrun,
    output logic                        o_busy
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_overrun;
    logic [NUM_CH-1:0] r_strobe;
    logic [CH_W-1:0]   r_ptr;

    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_expire;
    logic [NUM_CH-1:0] w_cand;
    logic [NUM_CH-1:0] w_grant;
    logic [NUM_CH-1:0] w_ovr_set;
    logic              w_grant_any;
    logic [CH_W-1:0]   w_grant_idx;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [PERIOD_W-1:0] r_period;
        logic [PERIOD_W-1:0] r_cnt;

        assign w_wr[gi]     = i_cfg_valid && (i_cfg_ch == CH_W'(gi));
        assign w_expire[gi] = i_tick && !w_wr[gi] && (r_period != '0) && (r_cnt == '0);

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_period <= '0;
                r_cnt    <= '0;
            end else if (w_wr[gi]) begin
                r_period <= i_cfg_period;
                r_cnt    <= (i_cfg_period == '0) ? '0 : i_cfg_period - 1'b1;
            end else if (i_tick && (r_period != '0)) begin
                // The counter only ever wraps through the reload, never past zero.
                r_cnt <= (r_cnt == '0) ? r_period - 1'b1 : r_cnt - 1'b1;
            end
        end
    end

    // Only requests pending before this tick compete; a channel being reconfigured is excluded.
    assign w_cand = r_pending & ~w_wr;

    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        if (i_tick) begin
            for (int i = 0; i < NUM_CH; i++) begin
                v_idx = (int'(r_ptr) + i) % NUM_CH;
                if (!w_grant_any && w_cand[v_idx]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = CH_W'(v_idx);
                end
            end
        end
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_ovr_set = w_expire & r_pending & ~w_grant;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pending <= '0;
            r_overrun <= '0;
            r_strobe  <= '0;
            r_ptr     <= '0;
        end else begin
            r_strobe  <= w_grant;
            r_pending <= ((r_pending & ~w_grant) | w_expire) & ~w_wr;
            // A new overrun outranks a clear arriving in the same cycle.
            r_overrun <= (w_ovr_set | (r_overrun & ~i_clear_overrun)) & ~w_wr;
            if (w_grant_any) begin
                r_ptr <= (w_grant_idx == CH_W'(NUM_CH - 1)) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    assign o_strobe  = r_strobe;
    assign o_overrun = r_overrun;
    assign o_busy    = |r_pending;

endmodule

// File: tb/tb_strobe_sched.sv
// Scoreboard bench for strobe_sched: a behavioural model queues the expected outputs
// of every cycle, which are popped and compared after the clock edge.
module tb_strobe_sched;

    localparam int NC = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [PW-1:0] cfg_period = '0;
    logic [NC-1:0] clr_ovr = '0;
    logic [NC-1:0] o_strobe;
    logic [NC-1:0] o_overrun;
    logic          o_busy;

    strobe_sched #(.NUM_CH(NC), .PERIOD_W(PW)) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_tick          (tick),
        .i_cfg_valid     (cfg_valid),
        .i_cfg_ch        (cfg_ch),
        .i_cfg_period    (cfg_period),
        .i_clear_overrun (clr_ovr),
        .o_strobe        (o_strobe),
        .o_overrun       (o_overrun),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0] strobe;
        logic [NC-1:0] ovr;
        logic          busy;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    string         phase = "init";
    logic [PW-1:0] m_per [NC];
    logic [PW-1:0] m_cnt [NC];
    logic [NC-1:0] m_pend;
    logic [NC-1:0] m_ovr;
    int            m_last;
    logic [NC-1:0] obs_strobe;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            m_per[c] = '0;
            m_cnt[c] = '0;
        end
        m_pend = '0;
        m_ovr  = '0;
        m_last = NC - 1;
        exp_q.delete();
    endtask

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic step(input logic t, input logic cv, input int ch, input int per, input logic [NC-1:0] clr);
        logic [NC-1:0] wr, ex, gnt, oset;
        logic          found;
        exp_t          e;
        tick       = t;
        cfg_valid  = cv;
        cfg_ch     = 2'(ch);
        cfg_period = PW'(per);
        clr_ovr    = clr;
        wr = '0;
        if (cv) wr[ch] = 1'b1;
        gnt   = '0;
        ex    = '0;
        found = 1'b0;
        if (t) begin
            for (int k = 1; k <= NC; k++) begin
                int c;
                c = (m_last + k) % NC;
                if (!found && m_pend[c] && !wr[c]) begin
                    found  = 1'b1;
                    gnt[c] = 1'b1;
                end
            end
            for (int c = 0; c < NC; c++) begin
                if (gnt[c]) m_last = c;
                if (!wr[c] && m_per[c] != 0) begin
                    if (m_cnt[c] == 0) begin
                        ex[c]    = 1'b1;
                        m_cnt[c] = m_per[c] - 8'd1;
                    end else begin
                        m_cnt[c] = m_cnt[c] - 8'd1;
                    end
                end
            end
        end
        oset   = ex & m_pend & ~gnt;
        m_pend = ((m_pend & ~gnt) | ex) & ~wr;
        m_ovr  = (oset | (m_ovr & ~clr)) & ~wr;
        if (cv) begin
            m_per[ch] = PW'(per);
            m_cnt[ch] = (per == 0) ? '0 : PW'(per - 1);
        end
        e.strobe = gnt;
        e.ovr    = m_ovr;
        e.busy   = |m_pend;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("strobe", 32'(o_strobe), 32'(e.strobe));
        check_val("overrun", 32'(o_overrun), 32'(e.ovr));
        check_val("busy", 32'(o_busy), 32'(e.busy));
        obs_strobe = o_strobe;
        tick      = 1'b0;
        cfg_valid = 1'b0;
        clr_ovr   = '0;
    endtask

    // Assert reset between clock edges; outputs must clear without any edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_strobe", 32'(o_strobe), 32'd0);
        check_val("rst_overrun", 32'(o_overrun), 32'd0);
        check_val("rst_busy", 32'(o_busy), 32'd0);
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic cfg(input int ch, input int per);
        step(1'b0, 1'b1, ch, per, '0);
    endtask

    initial begin
        int cnt, first;
        int order[$];

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        do_reset();

        phase = "p3";
        cfg(0, 3);
        cnt   = 0;
        first = -1;
        for (int t = 1; t <= 10; t++) begin
            step(1'b1, 1'b0, 0, 0, '0);
            if (obs_strobe[0]) begin
                cnt++;
                if (first < 0) first = t;
            end
        end
        check_val("first_tick", 32'(first), 32'd4);
        check_val("pulses", 32'(cnt), 32'd3);
        check_val("no_overrun", 32'(o_overrun), 32'd0);

        phase = "rr";
        do_reset();
        for (int c = 0; c < NC; c++) cfg(c, 1);
        for (int t = 1; t <= 9; t++) begin
            step(1'b1, 1'b0, 0, 0, '0);
            for (int c = 0; c < NC; c++) if (obs_strobe[c]) order.push_back(c);
            if (t == 2) check_val("ovr_tick2", 32'(o_overrun), 32'h0000000e);
        end
        check_val("n_grants", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size(); i++) check_val("order", 32'(order[i]), 32'(i % NC));
        step(1'b0, 1'b0, 0, 0, 4'b1111);
        check_val("cleared", 32'(o_overrun), 32'd0);

        phase = "grant_expire";
        do_reset();
        cfg(2, 1);
        step(1'b1, 1'b0, 0, 0, '0);
        step(1'b1, 1'b0, 0, 0, '0);
        check_val("strobe2", 32'(obs_strobe), 32'h4);
        check_val("pending2", 32'(o_busy), 32'd1);
        check_val("ovr2", 32'(o_overrun[2]), 32'd0);

        phase = "cfg_wins";
        do_reset();
        cfg(1, 2);
        step(1'b1, 1'b0, 0, 0, '0);
        step(1'b1, 1'b0, 0, 0, '0);
        check_val("pending_before", 32'(o_busy), 32'd1);
        step(1'b1, 1'b1, 1, 5, '0);
        check_val("no_grant", 32'(obs_strobe), 32'd0);
        check_val("pending_cleared", 32'(o_busy), 32'd0);
        for (int t = 1; t <= 6; t++) begin
            step(1'b1, 1'b0, 0, 0, '0);
            if (t == 4) check_val("not_yet", 32'(o_busy), 32'd0);
            if (t == 5) check_val("expired5", 32'(o_busy), 32'd1);
            if (t == 6) check_val("strobe1", 32'(obs_strobe), 32'h2);
        end

        phase = "disable";
        do_reset();
        cfg(0, 2);
        cfg(1, 3);
        cfg(3, 4);
        for (int t = 0; t < 12; t++) step(1'b1, 1'b0, 0, 0, '0);
        step(1'b1, 1'b1, 0, 0, '0);
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            step(1'b1, 1'b0, 0, 0, '0);
            if (obs_strobe[0]) cnt++;
        end
        check_val("ch0_silent", 32'(cnt), 32'd0);

        phase = "random";
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [NC-1:0] clr;
            clr = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0;
            step($urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, NC - 1)), int'($urandom_range(0, 6)), clr);
        end

        phase = "async_reset";
        do_reset();
        cfg(0, 1);
        cfg(1, 1);
        for (int t = 0; t < 3; t++) step(1'b1, 1'b0, 0, 0, '0);
        check_val("busy_before", 32'(o_busy), 32'd1);
        do_reset();
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            step(1'b1, 1'b0, 0, 0, '0);
            if (|obs_strobe) cnt++;
        end
        check_val("no_strobe_after", 32'(cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
